// File: rtl/lidar_tx_pkg.sv
// Shared types and constants for the LIDAR frame transmitter.
// Holds the serializer state encoding, UART framing constants and default header.
package lidar_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_STOP_BITS = 1;

    localparam logic [15:0] DEFAULT_HEADER = 16'h55AA;

endpackage

// File: rtl/uart_tx_byte.sv
// Byte serializer: 8N1 UART with back-to-back byte chaining.
// A new byte offered during the last stop-bit cycle starts with no idle gap.
module uart_tx_byte
    import lidar_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       byte_valid,
    output logic       byte_ready,
    input  logic [7:0] byte_data,
    output logic       tx,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0] DATA_LAST = 3'(UART_DATA_BITS - 1);
    localparam logic [2:0] STOP_LAST = 3'(UART_STOP_BITS - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             bit_last;
    logic             stop_done;
    logic             take;

    assign bit_last  = bit_cnt == BIT_LAST;
    assign stop_done = bit_last && (bit_idx == STOP_LAST);
    assign take      = byte_valid && byte_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (byte_valid) state_next = START;
            START:   if (bit_last) state_next = DATA;
            DATA:    if (bit_last && bit_idx == DATA_LAST) state_next = STOP;
            STOP:    if (stop_done) state_next = byte_valid ? START : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tx         = 1'b1;
        busy       = 1'b1;
        byte_ready = 1'b0;
        case (state)
            IDLE: begin
                busy       = 1'b0;
                byte_ready = 1'b1;
            end
            START:   tx = 1'b0;
            DATA:    tx = shreg[bit_idx];
            STOP:    byte_ready = stop_done;
            default: busy = 1'b0;
        endcase
    end

    // bit_idx counts data bits in DATA and stop bits in STOP
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (state == IDLE || bit_last) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (state_next != state) begin
                bit_idx <= '0;
            end else if (bit_last) begin
                bit_idx <= bit_idx + 1'b1;
            end
            if (take) begin
                shreg <= byte_data;
            end
        end
    end

endmodule

// File: rtl/lidar_frame_tx.sv
// LIDAR frame transmitter: header, snapshot payload, optional XOR checksum.
// Define LIDAR_FRAME_TX_CHECKSUM_EN to append the checksum byte.
module lidar_frame_tx
    import lidar_tx_pkg::*;
#(
    parameter int          CLKS_PER_BIT  = 16,
    parameter int          PAYLOAD_BYTES = 6,
    parameter logic [15:0] HEADER        = DEFAULT_HEADER
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  logic [8*PAYLOAD_BYTES-1:0] payload,
    output logic                       tx,
    output logic                       tx_busy,
    output logic                       frame_done
);

`ifdef LIDAR_FRAME_TX_CHECKSUM_EN
    localparam int CSUM_BYTES = 1;
`else
    localparam int CSUM_BYTES = 0;
`endif
    localparam int NBYTES = 2 + PAYLOAD_BYTES + CSUM_BYTES;
    localparam int IDX_W  = $clog2(PAYLOAD_BYTES + 3);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

    logic [8*PAYLOAD_BYTES-1:0] snapshot;
    logic [8*NBYTES-1:0]        frame_vec;
    logic [IDX_W-1:0]           byte_idx;
    logic [7:0]                 byte_data;
    logic                       armed;
    logic                       accept;
    logic                       byte_valid;
    logic                       byte_ready;
    logic                       byte_end;
    logic                       last_byte;
    logic                       ser_busy;
    int                         sel;

`ifdef LIDAR_FRAME_TX_CHECKSUM_EN
    logic [7:0] csum;

    always_comb begin
        csum = HEADER[15:8] ^ HEADER[7:0];
        for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            csum = csum ^ snapshot[8*i +: 8];
        end
    end

    assign frame_vec = {HEADER, snapshot, csum};
`else
    assign frame_vec = {HEADER, snapshot};
`endif

    assign load_ready = armed && !ser_busy;
    assign accept     = load_valid && load_ready;
    assign byte_end   = ser_busy && byte_ready;
    assign last_byte  = byte_idx == IDX_LAST;
    assign byte_valid = accept || (byte_end && !last_byte);
    assign tx_busy    = ser_busy;

    // frame_vec holds the first byte in its top slot
    always_comb begin
        sel       = accept ? NBYTES - 1 : NBYTES - 2 - int'(byte_idx);
        byte_data = frame_vec[8*NBYTES-1 -: 8];
        for (int i = 0; i < NBYTES; i++) begin
            if (i == sel) byte_data = frame_vec[8*i +: 8];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            armed      <= 1'b0;
            snapshot   <= '0;
            byte_idx   <= '0;
            frame_done <= 1'b0;
        end else begin
            armed      <= 1'b1;
            frame_done <= 1'b0;
            if (accept) begin
                snapshot <= payload;
                byte_idx <= '0;
            end else if (byte_end) begin
                if (last_byte) begin
                    byte_idx   <= '0;
                    frame_done <= 1'b1;
                end else begin
                    byte_idx <= byte_idx + 1'b1;
                end
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .clock     (clock),
        .reset     (reset),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .byte_data (byte_data),
        .tx        (tx),
        .busy      (ser_busy)
    );

endmodule
